// File: rtl/toggle_scheduler.sv
// toggle_scheduler
//   Shares one simple_toggle between N_REQ requesters. A round-robin arbiter
//   grants one requester, then a sequencer drives en with a burst of
//   single-cycle pulses and checks that q inverts after every pulse.
//
// Ports
//   clk      rising-edge clock
//   reset    asynchronous, active-high reset
//   req      per-requester request level, held until that requester's done
//   req_len  pulse count per requester, requester i at [i*CNT_W +: CNT_W]
//   gnt      one-hot grant, high for the whole burst including the done cycle
//   done     one-cycle pulse on the granted bit at the end of the burst
//   busy     high whenever the sequencer is not idle
//   en       registered enable to simple_toggle
//   q        simple_toggle output
//   err      sticky flag: q failed to invert after a pulse
module toggle_scheduler #(
  parameter int N_REQ = 4,
  parameter int CNT_W = 4,
  parameter int GAP   = 1
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [N_REQ-1:0]       req,
  input  logic [N_REQ*CNT_W-1:0] req_len,
  output logic [N_REQ-1:0]       gnt,
  output logic [N_REQ-1:0]       done,
  output logic                   busy,
  output logic                   en,
  input  logic                   q,
  output logic                   err
);

  localparam int PTR_W = $clog2(N_REQ);
  localparam int GAP_W = (GAP < 2) ? 1 : $clog2(GAP);

  typedef enum logic [1:0] {S_IDLE, S_PULSE, S_GAP, S_DONE} state_t;

  state_t             state;
  logic [PTR_W-1:0]   ptr;
  logic [PTR_W-1:0]   gnt_idx;
  logic [CNT_W-1:0]   cnt;
  logic [GAP_W-1:0]   gap_cnt;
  logic               q_ref;
  logic               chk_pending;

  logic               pick_valid;
  logic [PTR_W-1:0]   pick_idx;
  logic [CNT_W-1:0]   pick_len;

  // Round-robin pick: first set request at or after ptr, wrapping. Scanning
  // offsets from the far end down lets the nearest one overwrite the others.
  always_comb begin
    pick_valid = 1'b0;
    pick_idx   = '0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      if (req[(int'(ptr) + k) % N_REQ]) begin
        pick_valid = 1'b1;
        pick_idx   = PTR_W'((int'(ptr) + k) % N_REQ);
      end
    end
  end

  assign pick_len = req_len[int'(pick_idx)*CNT_W +: CNT_W];

  // Sequencer. A normal burst enters DONE with done already set, so DONE
  // lasts one cycle. A zero-length grant enters DONE with done clear and
  // spends one extra cycle there, giving the requester a grant cycle of its
  // own before the done pulse.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= S_IDLE;
      ptr     <= '0;
      gnt_idx <= '0;
      cnt     <= '0;
      gap_cnt <= '0;
      gnt     <= '0;
      done    <= '0;
      busy    <= 1'b0;
      en      <= 1'b0;
    end else begin
      done <= '0;
      en   <= 1'b0;
      case (state)
        S_IDLE: begin
          if (pick_valid) begin
            gnt     <= {{(N_REQ-1){1'b0}}, 1'b1} << pick_idx;
            gnt_idx <= pick_idx;
            busy    <= 1'b1;
            cnt     <= pick_len;
            if (pick_len != '0) begin
              en    <= 1'b1;
              state <= S_PULSE;
            end else begin
              state <= S_DONE;
            end
          end
        end
        S_PULSE: begin
          // cnt is at least 1 here, so the decrement never wraps.
          cnt <= cnt - CNT_W'(1);
          if (cnt == CNT_W'(1)) begin
            done  <= gnt;
            state <= S_DONE;
          end else if (GAP > 0) begin
            gap_cnt <= GAP_W'(GAP - 1);
            state   <= S_GAP;
          end else begin
            en <= 1'b1;
          end
        end
        S_GAP: begin
          if (gap_cnt == '0) begin
            en    <= 1'b1;
            state <= S_PULSE;
          end else begin
            gap_cnt <= gap_cnt - GAP_W'(1);
          end
        end
        S_DONE: begin
          if (done == '0) begin
            done <= gnt;
          end else begin
            gnt   <= '0;
            busy  <= 1'b0;
            ptr   <= (gnt_idx == PTR_W'(N_REQ - 1)) ? '0 : gnt_idx + PTR_W'(1);
            state <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Toggle check: q seen during a pulse is the reference, and on the cycle
  // after the pulse q must be its inverse. Runs independently of the state
  // so a check still pending while in DONE is evaluated too.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      q_ref       <= 1'b0;
      chk_pending <= 1'b0;
      err         <= 1'b0;
    end else begin
      chk_pending <= en;
      if (en) begin
        q_ref <= q;
      end
      if (chk_pending && (q == q_ref)) begin
        err <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_toggle_scheduler.sv
// tb_toggle_scheduler
//   Directed bench for toggle_scheduler (N_REQ=4, CNT_W=4, GAP=1). A small
//   behavioural simple_toggle drives q; it can be forced stuck at 0.
module tb_toggle_scheduler;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  req;
  logic [15:0] req_len;
  logic [3:0]  gnt;
  logic [3:0]  done;
  logic        busy;
  logic        en;
  logic        q;
  logic        err;
  logic        stuck;

  int n_compared   = 0;
  int n_mismatched = 0;

  toggle_scheduler #(.N_REQ(4), .CNT_W(4), .GAP(1)) dut (
    .clk     (clk),
    .reset   (reset),
    .req     (req),
    .req_len (req_len),
    .gnt     (gnt),
    .done    (done),
    .busy    (busy),
    .en      (en),
    .q       (q),
    .err     (err)
  );

  always #5 clk = ~clk;

  // Model of simple_toggle: q inverts on every clock edge with en high.
  always @(posedge clk or posedge reset) begin
    if (reset)      q <= 1'b0;
    else if (stuck) q <= 1'b0;
    else if (en)    q <= ~q;
  end

  function automatic logic [15:0] pack(input int l3, input int l2, input int l1, input int l0);
    return {4'(l3), 4'(l2), 4'(l1), 4'(l0)};
  endfunction

  task automatic check_output(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_compared++;
    if (got !== exp) begin
      n_mismatched++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic apply_stimulus(input logic [3:0] r, input logic [15:0] l);
    req     = r;
    req_len = l;
  endtask

  // Advance one clock and return at the following falling edge.
  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    logic [5:0] en_pat;
    reset = 1'b1;
    stuck = 1'b0;
    apply_stimulus(4'b1111, 16'hFFFF);

    // 1: reset held with every request set
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check_output("rst_gnt", 16'(gnt), 16'h0);
      check_output("rst_en", 16'(en), 16'h0);
      check_output("rst_busy", 16'(busy), 16'h0);
      check_output("rst_err", 16'(err), 16'h0);
    end
    reset = 1'b0;
    apply_stimulus(4'b0000, 16'h0);
    step();

    // 2: len 3 burst on requester 0, en 1,0,1,0,1 then done
    apply_stimulus(4'b0001, pack(0, 0, 0, 3));
    en_pat = 6'b010101;
    for (int c = 0; c < 6; c++) begin
      step();
      check_output("t2_en", 16'(en), 16'(en_pat[c]));
      check_output("t2_gnt", 16'(gnt), 16'h1);
      check_output("t2_done", 16'(done), (c == 5) ? 16'h1 : 16'h0);
    end
    apply_stimulus(4'b0000, 16'h0);
    step();
    check_output("t2_gnt_off", 16'(gnt), 16'h0);
    check_output("t2_busy_off", 16'(busy), 16'h0);
    check_output("t2_q", 16'(q), 16'h1);
    check_output("t2_err", 16'(err), 16'h0);

    // 3: round robin between requesters 1 and 3, then 0 from pointer 0
    apply_stimulus(4'b1010, pack(1, 0, 1, 0));
    step();
    check_output("t3_gnt1", 16'(gnt), 16'h2);
    check_output("t3_en1", 16'(en), 16'h1);
    step();
    check_output("t3_done1", 16'(done), 16'h2);
    apply_stimulus(4'b1000, pack(1, 0, 1, 0));
    step();
    check_output("t3_gap_gnt", 16'(gnt), 16'h0);
    step();
    check_output("t3_gnt3", 16'(gnt), 16'h8);
    step();
    check_output("t3_done3", 16'(done), 16'h8);
    apply_stimulus(4'b0001, pack(0, 0, 0, 1));
    step();
    step();
    check_output("t3_gnt0", 16'(gnt), 16'h1);
    step();
    check_output("t3_done0", 16'(done), 16'h1);
    apply_stimulus(4'b0000, 16'h0);
    step();

    // 4: zero-length burst on requester 2
    apply_stimulus(4'b0100, pack(0, 0, 0, 0));
    step();
    check_output("t4_gnt_a", 16'(gnt), 16'h4);
    check_output("t4_en_a", 16'(en), 16'h0);
    check_output("t4_done_a", 16'(done), 16'h0);
    step();
    check_output("t4_gnt_b", 16'(gnt), 16'h4);
    check_output("t4_en_b", 16'(en), 16'h0);
    check_output("t4_done_b", 16'(done), 16'h4);
    apply_stimulus(4'b0000, 16'h0);
    step();
    check_output("t4_gnt_off", 16'(gnt), 16'h0);
    check_output("t4_busy_off", 16'(busy), 16'h0);

    // 5: q stuck at 0 must raise a sticky err
    stuck = 1'b1;
    apply_stimulus(4'b0001, pack(0, 0, 0, 2));
    step();
    check_output("t5_en1", 16'(en), 16'h1);
    check_output("t5_gnt", 16'(gnt), 16'h1);
    step();
    check_output("t5_err_early", 16'(err), 16'h0);
    step();
    check_output("t5_err_set", 16'(err), 16'h1);
    step();
    check_output("t5_done", 16'(done), 16'h1);
    apply_stimulus(4'b0000, 16'h0);
    step();
    check_output("t5_err_sticky", 16'(err), 16'h1);
    check_output("t5_busy_off", 16'(busy), 16'h0);
    stuck = 1'b0;

    // 6: async reset during the gap of a len 5 burst
    apply_stimulus(4'b0001, pack(0, 0, 0, 5));
    step();
    check_output("t6_en1", 16'(en), 16'h1);
    step();
    check_output("t6_gap_busy", 16'(busy), 16'h1);
    #2 reset = 1'b1;
    #1;
    check_output("t6_rst_gnt", 16'(gnt), 16'h0);
    check_output("t6_rst_en", 16'(en), 16'h0);
    check_output("t6_rst_busy", 16'(busy), 16'h0);
    check_output("t6_rst_err", 16'(err), 16'h0);
    check_output("t6_rst_done", 16'(done), 16'h0);
    apply_stimulus(4'b0000, 16'h0);
    @(negedge clk);
    reset = 1'b0;
    step();
    check_output("t6_no_done", 16'(done), 16'h0);
    check_output("t6_idle_busy", 16'(busy), 16'h0);
    // Pointer back at 0: requester 0 wins over 3
    apply_stimulus(4'b1001, pack(1, 0, 0, 2));
    en_pat = 6'b000101;
    for (int c = 0; c < 4; c++) begin
      step();
      check_output("t6_en", 16'(en), 16'(en_pat[c]));
      check_output("t6_gnt", 16'(gnt), 16'h1);
      check_output("t6_done", 16'(done), (c == 3) ? 16'h1 : 16'h0);
    end
    apply_stimulus(4'b0000, 16'h0);
    step();
    check_output("t6_busy_off", 16'(busy), 16'h0);
    check_output("t6_err", 16'(err), 16'h0);
    check_output("t6_q", 16'(q), 16'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
